// File: rtl/axi_lite_pkg.sv
// Shared constants for the two-master AXI4-Lite arbiter.
// State encoding plus AXI response codes.
package axi_lite_pkg;

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] WRITE = 3'd1;
  localparam logic [2:0] WRESP = 3'd2;
  localparam logic [2:0] READ  = 3'd3;
  localparam logic [2:0] RDATA = 3'd4;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin pick; the last-grant register lives in the parent.
// On a tie the master that was not served last wins.
module rr_arb2 (
  input  logic [1:0] req_i,
  input  logic       last_grant_i,
  output logic [1:0] pick_o
);

  always_comb begin
    pick_o = req_i;
    if (&req_i) begin
      pick_o = last_grant_i ? 2'b01 : 2'b10;
    end
  end

endmodule

// File: rtl/axi_lite_arbiter.sv
// Two-master to one-slave AXI4-Lite arbiter, one transaction in flight.
// Round-robin grant held for a whole read or write transaction.
module axi_lite_arbiter
  import axi_lite_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [ADDR_W-1:0]   m0_awaddr,
  input  logic                m0_awvalid,
  output logic                m0_awready,
  input  logic [DATA_W-1:0]   m0_wdata,
  input  logic [DATA_W/8-1:0] m0_wstrb,
  input  logic                m0_wvalid,
  output logic                m0_wready,
  output logic [1:0]          m0_bresp,
  output logic                m0_bvalid,
  input  logic                m0_bready,
  input  logic [ADDR_W-1:0]   m0_araddr,
  input  logic                m0_arvalid,
  output logic                m0_arready,
  output logic [DATA_W-1:0]   m0_rdata,
  output logic [1:0]          m0_rresp,
  output logic                m0_rvalid,
  input  logic                m0_rready,
  input  logic [ADDR_W-1:0]   m1_awaddr,
  input  logic                m1_awvalid,
  output logic                m1_awready,
  input  logic [DATA_W-1:0]   m1_wdata,
  input  logic [DATA_W/8-1:0] m1_wstrb,
  input  logic                m1_wvalid,
  output logic                m1_wready,
  output logic [1:0]          m1_bresp,
  output logic                m1_bvalid,
  input  logic                m1_bready,
  input  logic [ADDR_W-1:0]   m1_araddr,
  input  logic                m1_arvalid,
  output logic                m1_arready,
  output logic [DATA_W-1:0]   m1_rdata,
  output logic [1:0]          m1_rresp,
  output logic                m1_rvalid,
  input  logic                m1_rready,
  output logic [ADDR_W-1:0]   s_awaddr,
  output logic                s_awvalid,
  input  logic                s_awready,
  output logic [DATA_W-1:0]   s_wdata,
  output logic [DATA_W/8-1:0] s_wstrb,
  output logic                s_wvalid,
  input  logic                s_wready,
  input  logic [1:0]          s_bresp,
  input  logic                s_bvalid,
  output logic                s_bready,
  output logic [ADDR_W-1:0]   s_araddr,
  output logic                s_arvalid,
  input  logic                s_arready,
  input  logic [DATA_W-1:0]   s_rdata,
  input  logic [1:0]          s_rresp,
  input  logic                s_rvalid,
  output logic                s_rready,
  output logic [1:0]          grant,
  output logic                busy
);

  localparam int STRB_W = DATA_W / 8;

  logic [2:0] state_q, state_d;
  logic [1:0] grant_q, grant_d;
  logic       last_q, last_d;
  logic       aw_done_q, aw_done_d;
  logic       w_done_q, w_done_d;

  logic [ADDR_W-1:0] m_awaddr [2];
  logic [ADDR_W-1:0] m_araddr [2];
  logic [DATA_W-1:0] m_wdata  [2];
  logic [STRB_W-1:0] m_wstrb  [2];
  logic [1:0]        m_awvalid, m_wvalid, m_arvalid;
  logic [1:0]        m_bready, m_rready;

  logic [1:0]        m_awready, m_wready, m_arready;
  logic [1:0]        m_bvalid, m_rvalid;
  logic [1:0]        m_bresp [2];
  logic [1:0]        m_rresp [2];
  logic [DATA_W-1:0] m_rdata [2];

  logic [1:0] req, pick;
  logic       sel;
  logic       aw_hs, w_hs;

  assign m_awaddr[0] = m0_awaddr;
  assign m_awaddr[1] = m1_awaddr;
  assign m_araddr[0] = m0_araddr;
  assign m_araddr[1] = m1_araddr;
  assign m_wdata[0]  = m0_wdata;
  assign m_wdata[1]  = m1_wdata;
  assign m_wstrb[0]  = m0_wstrb;
  assign m_wstrb[1]  = m1_wstrb;
  assign m_awvalid   = {m1_awvalid, m0_awvalid};
  assign m_wvalid    = {m1_wvalid, m0_wvalid};
  assign m_arvalid   = {m1_arvalid, m0_arvalid};
  assign m_bready    = {m1_bready, m0_bready};
  assign m_rready    = {m1_rready, m0_rready};

  assign m0_awready = m_awready[0];
  assign m1_awready = m_awready[1];
  assign m0_wready  = m_wready[0];
  assign m1_wready  = m_wready[1];
  assign m0_arready = m_arready[0];
  assign m1_arready = m_arready[1];
  assign m0_bvalid  = m_bvalid[0];
  assign m1_bvalid  = m_bvalid[1];
  assign m0_rvalid  = m_rvalid[0];
  assign m1_rvalid  = m_rvalid[1];
  assign m0_bresp   = m_bresp[0];
  assign m1_bresp   = m_bresp[1];
  assign m0_rresp   = m_rresp[0];
  assign m1_rresp   = m_rresp[1];
  assign m0_rdata   = m_rdata[0];
  assign m1_rdata   = m_rdata[1];

  assign req   = m_awvalid | m_arvalid;
  assign sel   = grant_q[1];
  assign grant = grant_q;
  assign busy  = (state_q != IDLE);

  rr_arb2 u_rr (
    .req_i        (req),
    .last_grant_i (last_q),
    .pick_o       (pick)
  );

  // Routing: only the granted master and the active channel see anything.
  always_comb begin
    s_awaddr   = '0;
    s_awvalid  = 1'b0;
    s_wdata    = '0;
    s_wstrb    = '0;
    s_wvalid   = 1'b0;
    s_bready   = 1'b0;
    s_araddr   = '0;
    s_arvalid  = 1'b0;
    s_rready   = 1'b0;
    m_awready  = '0;
    m_wready   = '0;
    m_arready  = '0;
    m_bvalid   = '0;
    m_rvalid   = '0;
    m_bresp[0] = RESP_OKAY;
    m_bresp[1] = RESP_OKAY;
    m_rresp[0] = RESP_OKAY;
    m_rresp[1] = RESP_OKAY;
    m_rdata[0] = '0;
    m_rdata[1] = '0;
    unique case (state_q)
      WRITE: begin
        s_awaddr       = m_awaddr[sel];
        s_awvalid      = m_awvalid[sel] & ~aw_done_q;
        m_awready[sel] = s_awready & ~aw_done_q;
        s_wdata        = m_wdata[sel];
        s_wstrb        = m_wstrb[sel];
        s_wvalid       = m_wvalid[sel] & ~w_done_q;
        m_wready[sel]  = s_wready & ~w_done_q;
      end
      WRESP: begin
        s_bready      = m_bready[sel];
        m_bvalid[sel] = s_bvalid;
        m_bresp[sel]  = s_bresp;
      end
      READ: begin
        s_araddr       = m_araddr[sel];
        s_arvalid      = m_arvalid[sel];
        m_arready[sel] = s_arready;
      end
      RDATA: begin
        s_rready      = m_rready[sel];
        m_rvalid[sel] = s_rvalid;
        m_rresp[sel]  = s_rresp;
        m_rdata[sel]  = s_rdata;
      end
      default: ;
    endcase
  end

  assign aw_hs = s_awvalid & s_awready;
  assign w_hs  = s_wvalid & s_wready;

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    last_d    = last_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    unique case (state_q)
      IDLE: begin
        if (|pick) begin
          grant_d = pick;
          state_d = m_awvalid[pick[1]] ? WRITE : READ;
        end
      end
      WRITE: begin
        if ((aw_done_q | aw_hs) && (w_done_q | w_hs)) begin
          state_d   = WRESP;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
        end else begin
          aw_done_d = aw_done_q | aw_hs;
          w_done_d  = w_done_q | w_hs;
        end
      end
      WRESP: begin
        if (s_bvalid && m_bready[sel]) begin
          state_d = IDLE;
          last_d  = sel;
          grant_d = '0;
        end
      end
      READ: begin
        if (s_arvalid && s_arready) begin
          state_d = RDATA;
        end
      end
      RDATA: begin
        if (s_rvalid && m_rready[sel]) begin
          state_d = IDLE;
          last_d  = sel;
          grant_d = '0;
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      grant_q   <= '0;
      last_q    <= 1'b1;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      last_q    <= last_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
    end
  end

endmodule

// File: tb/tb_axi_lite_arbiter.sv
// Directed scoreboard bench for axi_lite_arbiter.
// One process drives masters and a reactive slave model.
module tb_axi_lite_arbiter;
  import axi_lite_pkg::*;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = DW / 8;
  localparam logic [31:0] RKEY = 32'hA5A5_0000;

  logic clk, reset;

  logic [AW-1:0] m0_awaddr, m1_awaddr, m0_araddr, m1_araddr;
  logic [DW-1:0] m0_wdata, m1_wdata, m0_rdata, m1_rdata;
  logic [SW-1:0] m0_wstrb, m1_wstrb;
  logic m0_awvalid, m0_awready, m0_wvalid, m0_wready;
  logic m0_bvalid, m0_bready, m0_arvalid, m0_arready;
  logic m0_rvalid, m0_rready;
  logic m1_awvalid, m1_awready, m1_wvalid, m1_wready;
  logic m1_bvalid, m1_bready, m1_arvalid, m1_arready;
  logic m1_rvalid, m1_rready;
  logic [1:0] m0_bresp, m1_bresp, m0_rresp, m1_rresp;

  logic [AW-1:0] s_awaddr, s_araddr;
  logic [DW-1:0] s_wdata, s_rdata;
  logic [SW-1:0] s_wstrb;
  logic s_awvalid, s_awready, s_wvalid, s_wready;
  logic s_bvalid, s_bready, s_arvalid, s_arready;
  logic s_rvalid, s_rready;
  logic [1:0] s_bresp, s_rresp;
  logic [1:0] grant;
  logic busy;

  axi_lite_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .reset(reset),
    .m0_awaddr(m0_awaddr), .m0_awvalid(m0_awvalid), .m0_awready(m0_awready),
    .m0_wdata(m0_wdata), .m0_wstrb(m0_wstrb), .m0_wvalid(m0_wvalid),
    .m0_wready(m0_wready), .m0_bresp(m0_bresp), .m0_bvalid(m0_bvalid),
    .m0_bready(m0_bready), .m0_araddr(m0_araddr), .m0_arvalid(m0_arvalid),
    .m0_arready(m0_arready), .m0_rdata(m0_rdata), .m0_rresp(m0_rresp),
    .m0_rvalid(m0_rvalid), .m0_rready(m0_rready),
    .m1_awaddr(m1_awaddr), .m1_awvalid(m1_awvalid), .m1_awready(m1_awready),
    .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb), .m1_wvalid(m1_wvalid),
    .m1_wready(m1_wready), .m1_bresp(m1_bresp), .m1_bvalid(m1_bvalid),
    .m1_bready(m1_bready), .m1_araddr(m1_araddr), .m1_arvalid(m1_arvalid),
    .m1_arready(m1_arready), .m1_rdata(m1_rdata), .m1_rresp(m1_rresp),
    .m1_rvalid(m1_rvalid), .m1_rready(m1_rready),
    .s_awaddr(s_awaddr), .s_awvalid(s_awvalid), .s_awready(s_awready),
    .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid),
    .s_wready(s_wready), .s_bresp(s_bresp), .s_bvalid(s_bvalid),
    .s_bready(s_bready), .s_araddr(s_araddr), .s_arvalid(s_arvalid),
    .s_arready(s_arready), .s_rdata(s_rdata), .s_rresp(s_rresp),
    .s_rvalid(s_rvalid), .s_rready(s_rready),
    .grant(grant), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0]  g;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [1:0]  resp;
  } txn_t;

  txn_t expq[$];

  int checks = 0;
  int failures = 0;
  int n_aw = 0, n_w = 0, n_ar = 0, n_resp = 0, ar_in_wr = 0;
  int rd_left0 = 0, rd_left1 = 0;
  int base_aw, base_w, base_ar, base_resp, base_arw;

  logic aw_seen, w_seen, hold_b, rd_ovr_en;
  logic [1:0] slv_bresp, slv_rresp;
  logic [31:0] rd_ovr;

  logic [1:0]  sn_grant;
  logic        sn_busy, sn_s_awvalid, sn_s_wvalid, sn_m0_bvalid;
  logic [31:0] sn_awaddr, sn_wdata, sn_m0_rdata;
  logic [3:0]  sn_wstrb;
  logic [14:0] sn_allv;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [1:0] g, input logic wr,
                      input logic [31:0] a, input logic [31:0] d,
                      input logic [1:0] r);
    txn_t t;
    t.g = g; t.wr = wr; t.addr = a; t.data = d; t.resp = r;
    expq.push_back(t);
  endtask

  // Sample at negedge, then update masters and slave just after posedge.
  task automatic cycle();
    logic aw0, w0, ar0, aw1, w1, ar1;
    logic saw, sw, sar, sb, sr;
    logic [1:0] rv;
    logic [31:0] sar_addr;
    txn_t e;
    @(negedge clk);
    aw0 = m0_awvalid & m0_awready;
    w0  = m0_wvalid & m0_wready;
    ar0 = m0_arvalid & m0_arready;
    aw1 = m1_awvalid & m1_awready;
    w1  = m1_wvalid & m1_wready;
    ar1 = m1_arvalid & m1_arready;
    saw = s_awvalid & s_awready;
    sw  = s_wvalid & s_wready;
    sar = s_arvalid & s_arready;
    sb  = s_bvalid & s_bready;
    sr  = s_rvalid & s_rready;
    sar_addr = s_araddr;
    sn_grant = grant;
    sn_busy = busy;
    sn_s_awvalid = s_awvalid;
    sn_s_wvalid = s_wvalid;
    sn_m0_bvalid = m0_bvalid;
    sn_awaddr = s_awaddr;
    sn_wdata = s_wdata;
    sn_wstrb = s_wstrb;
    sn_m0_rdata = m0_rdata;
    sn_allv = {m0_awready, m0_wready, m0_bvalid, m0_arready, m0_rvalid,
               m1_awready, m1_wready, m1_bvalid, m1_arready, m1_rvalid,
               s_awvalid, s_wvalid, s_bready, s_arvalid, s_rready};
    if (s_arvalid && expq.size() > 0 && expq[0].wr) ar_in_wr++;
    if (saw) begin
      n_aw++;
      if (expq.size() == 0) chk("aw_unexpected", 32'(saw), 32'd0);
      else begin
        chk("s_awaddr", s_awaddr, expq[0].addr);
        chk("aw_grant", 32'(grant), 32'(expq[0].g));
      end
    end
    if (sw) begin
      n_w++;
      if (expq.size() > 0) chk("s_wdata", s_wdata, expq[0].data);
    end
    if (sar) begin
      n_ar++;
      if (expq.size() == 0) chk("ar_unexpected", 32'(sar), 32'd0);
      else begin
        chk("s_araddr", s_araddr, expq[0].addr);
        chk("ar_grant", 32'(grant), 32'(expq[0].g));
      end
    end
    rv = {m1_bvalid | m1_rvalid, m0_bvalid | m0_rvalid};
    if (rv != 2'b00) begin
      if (expq.size() == 0) chk("resp_unexpected", 32'(rv), 32'd0);
      else begin
        e = expq.pop_front();
        n_resp++;
        chk("resp_owner", 32'(rv), 32'(e.g));
        if (e.wr) begin
          chk("resp_is_b", 32'({m1_bvalid, m0_bvalid}), 32'(e.g));
          chk("bresp", 32'(e.g[1] ? m1_bresp : m0_bresp), 32'(e.resp));
        end else begin
          chk("resp_is_r", 32'({m1_rvalid, m0_rvalid}), 32'(e.g));
          chk("rdata", e.g[1] ? m1_rdata : m0_rdata, e.data);
          chk("rresp", 32'(e.g[1] ? m1_rresp : m0_rresp), 32'(e.resp));
        end
      end
    end
    @(posedge clk);
    #1;
    if (sb) s_bvalid = 1'b0;
    if (sr) s_rvalid = 1'b0;
    if (saw) aw_seen = 1'b1;
    if (sw) w_seen = 1'b1;
    if (aw_seen && w_seen && !s_bvalid && !hold_b) begin
      s_bvalid = 1'b1;
      s_bresp = slv_bresp;
      aw_seen = 1'b0;
      w_seen = 1'b0;
    end
    if (sar) begin
      s_rvalid = 1'b1;
      s_rdata = rd_ovr_en ? rd_ovr : (sar_addr ^ RKEY);
      s_rresp = slv_rresp;
    end
    if (aw0) m0_awvalid = 1'b0;
    if (w0) m0_wvalid = 1'b0;
    if (aw1) m1_awvalid = 1'b0;
    if (w1) m1_wvalid = 1'b0;
    if (ar0) begin
      if (rd_left0 > 0) begin rd_left0--; m0_araddr += 4; end
      else m0_arvalid = 1'b0;
    end
    if (ar1) begin
      if (rd_left1 > 0) begin rd_left1--; m1_araddr += 4; end
      else m1_arvalid = 1'b0;
    end
  endtask

  task automatic run_until_empty(input string tag, input int budget);
    int n = 0;
    while (expq.size() > 0 && n < budget) begin
      cycle();
      n++;
    end
    chk(tag, 32'(expq.size()), 32'd0);
  endtask

  task automatic clear_slave();
    s_bvalid = 1'b0; s_rvalid = 1'b0;
    s_bresp = RESP_OKAY; s_rresp = RESP_OKAY; s_rdata = '0;
    aw_seen = 1'b0; w_seen = 1'b0; hold_b = 1'b0;
    m0_awvalid = 1'b0; m0_wvalid = 1'b0; m0_arvalid = 1'b0;
    m1_awvalid = 1'b0; m1_wvalid = 1'b0; m1_arvalid = 1'b0;
    rd_left0 = 0; rd_left1 = 0;
    expq.delete();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    clear_slave();
    cycle();
    cycle();
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1;
    m0_awaddr = '0; m0_wdata = '0; m0_wstrb = '0; m0_araddr = '0;
    m1_awaddr = '0; m1_wdata = '0; m1_wstrb = '0; m1_araddr = '0;
    m0_bready = 1'b1; m0_rready = 1'b1; m1_bready = 1'b1; m1_rready = 1'b1;
    s_awready = 1'b1; s_wready = 1'b1; s_arready = 1'b1;
    slv_bresp = RESP_OKAY; slv_rresp = RESP_OKAY;
    rd_ovr_en = 1'b0; rd_ovr = '0;
    clear_slave();
    cycle();
    cycle();
    chk("rst_grant", 32'(sn_grant), 32'd0);
    chk("rst_busy", 32'(sn_busy), 32'd0);
    chk("rst_valids", 32'(sn_allv), 32'd0);
    chk("rst_s_awaddr", sn_awaddr, 32'd0);
    chk("rst_m0_rdata", sn_m0_rdata, 32'd0);
    reset = 1'b0;
    cycle();

    // Single m0 write, always-ready slave.
    m0_awaddr = 32'h1000; m0_wdata = 32'hDEADBEEF; m0_wstrb = 4'hF;
    m0_awvalid = 1'b1; m0_wvalid = 1'b1;
    push(2'b01, 1'b1, 32'h1000, 32'hDEADBEEF, RESP_OKAY);
    cycle();
    chk("t1_idle_grant", 32'(sn_grant), 32'd0);
    cycle();
    chk("t1_grant", 32'(sn_grant), 32'd1);
    chk("t1_s_awaddr", sn_awaddr, 32'h1000);
    chk("t1_s_wdata", sn_wdata, 32'hDEADBEEF);
    chk("t1_s_wstrb", 32'(sn_wstrb), 32'hF);
    chk("t1_busy", 32'(sn_busy), 32'd1);
    cycle();
    chk("t1_m0_bvalid", 32'(sn_m0_bvalid), 32'd1);
    chk("t1_grant_wresp", 32'(sn_grant), 32'd1);
    cycle();
    chk("t1_grant_after", 32'(sn_grant), 32'd0);
    chk("t1_busy_after", 32'(sn_busy), 32'd0);

    // Both masters stream reads from reset: strict alternation.
    do_reset();
    base_ar = n_ar;
    m0_araddr = 32'h2000; m1_araddr = 32'h3000;
    rd_left0 = 3; rd_left1 = 3;
    m0_arvalid = 1'b1; m1_arvalid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      push(2'b01, 1'b0, 32'h2000 + 32'(4 * k), (32'h2000 + 32'(4 * k)) ^ RKEY,
           RESP_OKAY);
      push(2'b10, 1'b0, 32'h3000 + 32'(4 * k), (32'h3000 + 32'(4 * k)) ^ RKEY,
           RESP_OKAY);
    end
    run_until_empty("t2_drain", 200);
    chk("t2_ar_count", 32'(n_ar - base_ar), 32'd8);

    // Slave takes AW two cycles before W.
    base_aw = n_aw; base_w = n_w; base_resp = n_resp;
    s_wready = 1'b0;
    m0_awaddr = 32'h1004; m0_wdata = 32'hCAFEF00D; m0_wstrb = 4'h3;
    m0_awvalid = 1'b1; m0_wvalid = 1'b1;
    push(2'b01, 1'b1, 32'h1004, 32'hCAFEF00D, RESP_OKAY);
    cycle();
    cycle();
    chk("t3_awvalid_first", 32'(sn_s_awvalid), 32'd1);
    cycle();
    chk("t3_awvalid_masked", 32'(sn_s_awvalid), 32'd0);
    chk("t3_wvalid_held", 32'(sn_s_wvalid), 32'd1);
    s_wready = 1'b1;
    run_until_empty("t3_drain", 20);
    cycle();
    cycle();
    chk("t3_aw_count", 32'(n_aw - base_aw), 32'd1);
    chk("t3_w_count", 32'(n_w - base_w), 32'd1);
    chk("t3_b_count", 32'(n_resp - base_resp), 32'd1);

    // m1 write and read together: write first, DECERR passed through.
    base_arw = ar_in_wr;
    slv_bresp = RESP_DECERR;
    m1_awaddr = 32'h4000; m1_wdata = 32'h0BADF00D; m1_wstrb = 4'hF;
    m1_araddr = 32'h4008; rd_left1 = 0;
    m1_awvalid = 1'b1; m1_wvalid = 1'b1; m1_arvalid = 1'b1;
    push(2'b10, 1'b1, 32'h4000, 32'h0BADF00D, RESP_DECERR);
    push(2'b10, 1'b0, 32'h4008, 32'h4008 ^ RKEY, RESP_OKAY);
    run_until_empty("t4_drain", 40);
    chk("t4_no_ar_in_write", 32'(ar_in_wr - base_arw), 32'd0);
    slv_bresp = RESP_OKAY;

    // SLVERR read with fixed data to m0.
    slv_rresp = RESP_SLVERR; rd_ovr_en = 1'b1; rd_ovr = 32'h12345678;
    m0_araddr = 32'h5000; m0_arvalid = 1'b1;
    push(2'b01, 1'b0, 32'h5000, 32'h12345678, RESP_SLVERR);
    run_until_empty("t5_drain", 20);
    cycle();
    chk("t5_idle_busy", 32'(sn_busy), 32'd0);
    chk("t5_idle_grant", 32'(sn_grant), 32'd0);
    slv_rresp = RESP_OKAY; rd_ovr_en = 1'b0;

    // Reset while waiting in WRESP, then a fresh m1 request.
    hold_b = 1'b1;
    m0_awaddr = 32'h6000; m0_wdata = 32'h66666666; m0_wstrb = 4'hF;
    m0_awvalid = 1'b1; m0_wvalid = 1'b1;
    push(2'b01, 1'b1, 32'h6000, 32'h66666666, RESP_OKAY);
    cycle();
    cycle();
    cycle();
    chk("t6_wresp_busy", 32'(sn_busy), 32'd1);
    chk("t6_wresp_nob", 32'(sn_m0_bvalid), 32'd0);
    reset = 1'b1;
    clear_slave();
    cycle();
    chk("t6_rst_busy", 32'(sn_busy), 32'd0);
    chk("t6_rst_grant", 32'(sn_grant), 32'd0);
    chk("t6_rst_valids", 32'(sn_allv), 32'd0);
    reset = 1'b0;
    cycle();
    m1_awaddr = 32'h7000; m1_wdata = 32'h77777777; m1_wstrb = 4'hF;
    m1_awvalid = 1'b1; m1_wvalid = 1'b1;
    push(2'b10, 1'b1, 32'h7000, 32'h77777777, RESP_OKAY);
    cycle();
    cycle();
    chk("t6_m1_grant", 32'(sn_grant), 32'd2);
    run_until_empty("t6_drain", 20);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
